// File: rtl/core_s2_seq_comparator.sv
// Chunk-serial stage-2 branch comparator: compares WIDTH-bit operands CHUNK_W bits per cycle, MSB chunk first.
// Optional macro CORE_S2_SEQ_COMPARATOR_EARLY_EXIT_EN ends the compare at the first differing chunk.
`timescale 1ns/1ps

package core_pkg;
  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_op_e;
endpackage

module core_s2_seq_comparator
  import core_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  cmp_op_e          req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_result,
  output logic             busy
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_valid and
  // rsp_result stay constant until that transfer or a flush.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state;
  cmp_op_e          op_q;
  logic [WIDTH-1:0] rs1_q, rs2_q;
  logic [IDX_W-1:0] idx;
  logic             eq_flag, lt_flag;

  logic [CHUNK_W-1:0] a_chunk, b_chunk;
  logic               signed_op, chunk_diff, chunk_lt;
  logic               nxt_eq, nxt_lt, last_step;

  function automatic logic op_result(input cmp_op_e op, input logic eq, input logic lt);
    case (op)
      CMP_EQ:           op_result = eq;
      CMP_NE:           op_result = ~eq;
      CMP_LT, CMP_LTU:  op_result = lt;
      CMP_GE, CMP_GEU:  op_result = ~lt;
      default:          op_result = 1'b0;
    endcase
  endfunction

  always_comb begin
    a_chunk   = rs1_q[int'(idx)*CHUNK_W +: CHUNK_W];
    b_chunk   = rs2_q[int'(idx)*CHUNK_W +: CHUNK_W];
    signed_op = (op_q == CMP_LT) || (op_q == CMP_GE);
    // Flipping the sign bit maps two's complement order onto unsigned order.
    if (signed_op && (idx == TOP_IDX)) begin
      a_chunk[CHUNK_W-1] = ~a_chunk[CHUNK_W-1];
      b_chunk[CHUNK_W-1] = ~b_chunk[CHUNK_W-1];
    end
    chunk_diff = (a_chunk != b_chunk);
    chunk_lt   = (a_chunk < b_chunk);
    nxt_eq     = eq_flag & ~chunk_diff;
    nxt_lt     = (eq_flag & chunk_diff) ? chunk_lt : lt_flag;
`ifdef CORE_S2_SEQ_COMPARATOR_EARLY_EXIT_EN
    last_step  = (idx == '0) || (eq_flag && chunk_diff);
`else
    last_step  = (idx == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= CMP_EQ;
      rs1_q      <= '0;
      rs2_q      <= '0;
      idx        <= TOP_IDX;
      eq_flag    <= 1'b1;
      lt_flag    <= 1'b0;
      rsp_result <= 1'b0;
    end else if (flush) begin
      state   <= S_IDLE;
      idx     <= TOP_IDX;
      eq_flag <= 1'b1;
      lt_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            idx     <= TOP_IDX;
            eq_flag <= 1'b1;
            lt_flag <= 1'b0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          eq_flag <= nxt_eq;
          lt_flag <= nxt_lt;
          if (last_step) begin
            rsp_result <= op_result(op_q, nxt_eq, nxt_lt);
            state      <= S_DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE) && !flush;
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_core_s2_seq_comparator.sv
// Directed scoreboard bench for core_s2_seq_comparator: 32/8 and 64/16 instances.
// Expected latencies follow CORE_S2_SEQ_COMPARATOR_EARLY_EXIT_EN when defined.
`timescale 1ns/1ps

module tb_core_s2_seq_comparator;
  import core_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_result, busy;
  cmp_op_e     req_op;
  logic [31:0] req_rs1, req_rs2;

  logic        w_rst_n, w_flush, w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready, w_rsp_result, w_busy;
  cmp_op_e     w_req_op;
  logic [63:0] w_req_rs1, w_req_rs2;

  core_s2_seq_comparator #(.WIDTH(32), .CHUNK_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy)
  );

  core_s2_seq_comparator #(.WIDTH(64), .CHUNK_W(16)) dut64 (
    .clk(clk), .rst_n(w_rst_n), .flush(w_flush),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op),
    .req_rs1(w_req_rs1), .req_rs2(w_req_rs2),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_result(w_rsp_result), .busy(w_busy)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];
  logic [0:0] exp64_q[$];
  int         lat64_q[$];
  int         acc64_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // monitors: pop on each rising rsp_valid
  logic       prev_v = 1'b0;
  logic       prev_v64 = 1'b0;
  logic [0:0] m_e, m64_e;
  int         m_l, m_a, m64_l, m64_a;

  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) fail_now("unexpected_rsp32", "rsp_valid rose with nothing outstanding");
        else begin
          m_e = exp_q.pop_front();
          m_l = lat_q.pop_front();
          m_a = acc_q.pop_front();
          check("rsp_result32", 64'(rsp_result), 64'(m_e));
          check("latency32", 64'(cyc - m_a), 64'(m_l));
        end
      end
      prev_v = rsp_valid;
    end
  end

  always @(negedge clk) begin
    if (!w_rst_n) prev_v64 = 1'b0;
    else begin
      if (w_rsp_valid && !prev_v64) begin
        if (exp64_q.size() == 0) fail_now("unexpected_rsp64", "rsp_valid rose with nothing outstanding");
        else begin
          m64_e = exp64_q.pop_front();
          m64_l = lat64_q.pop_front();
          m64_a = acc64_q.pop_front();
          check("rsp_result64", 64'(w_rsp_result), 64'(m64_e));
          check("latency64", 64'(cyc - m64_a), 64'(m64_l));
        end
      end
      prev_v64 = w_rsp_valid;
    end
  end

  // drivers
  task automatic issue32(input cmp_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input bit want, input logic e, input int lat_ee, input int lat_ct);
    int t;
    @(negedge clk);
    req_op = op; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
    #1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!req_ready) begin
      fail_now("accept32", "req_ready never rose");
      req_valid = 1'b0;
      return;
    end
    if (want) begin
      exp_q.push_back(e);
`ifdef CORE_S2_SEQ_COMPARATOR_EARLY_EXIT_EN
      lat_q.push_back(lat_ee);
`else
      lat_q.push_back(lat_ct);
`endif
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rs1 = $urandom;
    req_rs2 = $urandom;
  endtask

  task automatic issue64(input cmp_op_e op, input logic [63:0] a, input logic [63:0] b,
                         input bit want, input logic e, input int lat_ee, input int lat_ct);
    int t;
    @(negedge clk);
    w_req_op = op; w_req_rs1 = a; w_req_rs2 = b; w_req_valid = 1'b1;
    #1;
    t = 0;
    while (!w_req_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!w_req_ready) begin
      fail_now("accept64", "req_ready never rose");
      w_req_valid = 1'b0;
      return;
    end
    if (want) begin
      exp64_q.push_back(e);
`ifdef CORE_S2_SEQ_COMPARATOR_EARLY_EXIT_EN
      lat64_q.push_back(lat_ee);
`else
      lat64_q.push_back(lat_ct);
`endif
      acc64_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    w_req_valid = 1'b0;
    w_req_rs1 = {$urandom, $urandom};
    w_req_rs2 = {$urandom, $urandom};
  endtask

  task automatic wait_idle32();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 60);
    if (busy) fail_now("idle32_timeout", "block stayed busy");
  endtask

  task automatic wait_idle64();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (w_busy && t < 60);
    if (w_busy) fail_now("idle64_timeout", "block stayed busy");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = CMP_EQ;
    req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b1;
    w_rst_n = 1'b0; w_flush = 1'b0; w_req_valid = 1'b0; w_req_op = CMP_EQ;
    w_req_rs1 = '0; w_req_rs2 = '0; w_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready32", 64'(req_ready), 64'd1);
    check("reset_rsp_valid32", 64'(rsp_valid), 64'd0);
    check("reset_rsp_result32", 64'(rsp_result), 64'd0);
    check("reset_busy32", 64'(busy), 64'd0);
    check("reset_req_ready64", 64'(w_req_ready), 64'd1);
    check("reset_busy64", 64'(w_busy), 64'd0);
    rst_n = 1'b1;
    w_rst_n = 1'b1;

    // directed vectors: op, rs1, rs2, expected result, latency with / without early exit
    issue32(CMP_EQ,  32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b1, 4, 4); wait_idle32();
    issue32(CMP_LT,  32'h80000000, 32'h00000001, 1, 1'b1, 1, 4); wait_idle32();
    issue32(CMP_LTU, 32'h80000000, 32'h00000001, 1, 1'b0, 1, 4); wait_idle32();
    issue32(CMP_GEU, 32'h12345678, 32'h12345679, 1, 1'b0, 4, 4); wait_idle32();
    issue32(CMP_GE,  32'h00000005, 32'hFFFFFFFB, 1, 1'b1, 1, 4); wait_idle32();
    issue32(CMP_NE,  32'h00001234, 32'h00001234, 1, 1'b0, 4, 4); wait_idle32();
    issue32(CMP_LTU, 32'h00FF0000, 32'h00FE0000, 1, 1'b0, 2, 4); wait_idle32();
    issue32(cmp_op_e'(3'b010), 32'h00000001, 32'h00000002, 1, 1'b0, 4, 4); wait_idle32();
    issue32(CMP_EQ,  32'h00000000, 32'h00000000, 1, 1'b1, 4, 4); wait_idle32();

    // backpressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    issue32(CMP_GEU, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1, 1, 4);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    if (!rsp_valid) fail_now("bp_rsp_timeout", "rsp_valid never rose");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_result", 64'(rsp_result), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req_ready", 64'(req_ready), 64'd1);
    check("bp_release_rsp_valid", 64'(rsp_valid), 64'd0);

    // flush during the second BUSY cycle: no response
    issue32(CMP_NE, 32'hFF000000, 32'hFF000001, 0, 1'b1, 4, 4);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_req_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (6) @(negedge clk);
    issue32(CMP_NE, 32'hFF000000, 32'hFF000001, 1, 1'b1, 4, 4); wait_idle32();

    // 64-bit instance, 16-bit chunks
    issue64(CMP_GE,  64'hFFFFFFFF_FFFFFFFF, 64'h0, 1, 1'b0, 1, 4); wait_idle64();
    issue64(CMP_GE,  64'd5, 64'd5, 0, 1'b1, 4, 4);
    @(posedge clk);
    @(posedge clk);
    #2;
    w_rst_n = 1'b0;
    #1;
    check("arst_rsp_valid64", 64'(w_rsp_valid), 64'd0);
    check("arst_req_ready64", 64'(w_req_ready), 64'd1);
    check("arst_busy64", 64'(w_busy), 64'd0);
    @(negedge clk);
    w_rst_n = 1'b1;
    issue64(CMP_LTU, 64'h00000001_00000000, 64'h2, 1, 1'b0, 2, 4); wait_idle64();
    issue64(CMP_EQ,  64'hA5A5_0000_1111_2222, 64'hA5A5_0000_1111_2222, 1, 1'b1, 4, 4); wait_idle64();

    repeat (3) @(negedge clk);
    check("queue_empty32", 64'(exp_q.size()), 64'd0);
    check("queue_empty64", 64'(exp64_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
